// File: rtl/typed_param_streamer_pkg.sv
// Shared types and elaboration-time helpers for typed_param_streamer.
package typed_param_streamer_pkg;

  typedef enum logic [2:0] {IDLE, HDR, MSG, CHK, DONE} state_e;

  // Widest output word the packing helper can build.
  localparam int MAX_W = 1024;

  function automatic int ceil_div(int a, int b);
    return (b > 0) ? (a + b - 1) / b : 0;
  endfunction

  // Word idx of string s packed w/8 chars per word, lowest-index char in bits [7:0].
  function automatic logic [MAX_W-1:0] pack_word(string s, int idx, int w);
    logic [MAX_W-1:0] word;
    int               cpw;
    int               c;
    word = '0;
    cpw  = w / 8;
    for (int b = 0; b < cpw && b < MAX_W / 8; b++) begin
      c = idx * cpw + b;
      if (c < s.len()) word[b*8 +: 8] = s[c];
    end
    return word;
  endfunction

endpackage

// File: rtl/typed_param_streamer_oreg.sv
// Output holding register: loads when empty or when the held word is being
// accepted, so data stays frozen under backpressure.
module typed_param_streamer_oreg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/typed_param_streamer.sv
// Streams a header word and a packed string on a valid/ready bus.
// Optional checksum word: define TYPED_PARAM_STREAMER_CHECKSUM_EN.
module typed_param_streamer
  import typed_param_streamer_pkg::*;
#(
  parameter int    DATA_W        = 8,
  parameter int    INTEGER_PARAM = 10,
  parameter string STRING_PARAM  = "test",
  parameter bit    REPEAT        = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CPW    = DATA_W / 8;
  localparam int LEN    = STRING_PARAM.len();
  localparam int NW     = ceil_div(LEN, CPW);
  localparam int NW_ARR = (NW > 0) ? NW : 1;
  localparam int CNT_W  = (NW > 0) ? $clog2(NW + 1) : 1;

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_HDR  = HDR;
  localparam logic [2:0] ST_MSG  = MSG;
  localparam logic [2:0] ST_CHK  = CHK;
  localparam logic [2:0] ST_DONE = DONE;

  if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MAX_W) begin : g_bad_width
    $error("typed_param_streamer: DATA_W must be a multiple of 8 in [8, MAX_W]");
  end
  if (INTEGER_PARAM < 0) begin : g_bad_int
    $error("typed_param_streamer: INTEGER_PARAM must be non-negative");
  end

  function automatic logic [NW_ARR*DATA_W-1:0] build_rom();
    logic [NW_ARR*DATA_W-1:0] rom;
    logic [MAX_W-1:0]         w;
    rom = '0;
    for (int k = 0; k < NW; k++) begin
      w = pack_word(STRING_PARAM, k, DATA_W);
      rom[k*DATA_W +: DATA_W] = w[DATA_W-1:0];
    end
    return rom;
  endfunction

  localparam logic [NW_ARR*DATA_W-1:0] MSG_ROM  = build_rom();
  localparam logic [DATA_W-1:0]        HDR_WORD = DATA_W'(INTEGER_PARAM);
  localparam logic [CNT_W-1:0]         LAST_IDX = CNT_W'(NW_ARR - 1);

`ifdef TYPED_PARAM_STREAMER_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] xor_rom();
    logic [DATA_W-1:0] x;
    x = '0;
    for (int k = 0; k < NW; k++) x ^= MSG_ROM[k*DATA_W +: DATA_W];
    return x;
  endfunction

  localparam bit                CHK_EN     = 1'b1;
  localparam logic [2:0]        TAIL_STATE = ST_CHK;
  localparam logic [DATA_W-1:0] CHK_WORD   = xor_rom();
`else
  localparam bit                CHK_EN     = 1'b0;
  localparam logic [2:0]        TAIL_STATE = ST_DONE;
  localparam logic [DATA_W-1:0] CHK_WORD   = '0;
`endif

  localparam bit HDR_LAST = (NW == 0) && !CHK_EN;

  logic [2:0]        state, nxt_state;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              hs;
  int                sel_idx;
  logic [DATA_W-1:0] msg_word;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  assign hs      = out_valid && out_ready;
  assign sel_idx = (state == ST_MSG) ? int'(cnt) + 1 : 0;

  // NOTE: assign every always_comb output a default first so no latch is inferred.
  always_comb begin
    msg_word = '0;
    for (int k = 0; k < NW_ARR; k++)
      if (k == sel_idx) msg_word = MSG_ROM[k*DATA_W +: DATA_W];
  end

  always_comb begin
    nxt_state = state;
    cnt_nxt   = cnt;
    ld_valid  = 1'b0;
    ld_data   = HDR_WORD;
    ld_last   = HDR_LAST;
    case (state)
      ST_IDLE: if (start) begin
        nxt_state = ST_HDR;
        ld_valid  = 1'b1;
        cnt_nxt   = '0;
      end
      ST_HDR: if (hs) begin
        if (NW > 0) begin
          nxt_state = ST_MSG;
          ld_valid  = 1'b1;
          ld_data   = msg_word;
          ld_last   = (NW == 1) && !CHK_EN;
        end else begin
          nxt_state = TAIL_STATE;
          ld_valid  = CHK_EN;
          ld_data   = CHK_WORD;
          ld_last   = 1'b1;
        end
      end
      ST_MSG: if (hs) begin
        if (cnt != LAST_IDX) begin
          cnt_nxt  = cnt + CNT_W'(1);
          ld_valid = 1'b1;
          ld_data  = msg_word;
          ld_last  = (cnt + CNT_W'(1) == LAST_IDX) && !CHK_EN;
        end else begin
          nxt_state = TAIL_STATE;
          ld_valid  = CHK_EN;
          ld_data   = CHK_WORD;
          ld_last   = 1'b1;
        end
      end
      ST_CHK: if (hs) nxt_state = ST_DONE;
      ST_DONE: if (REPEAT) begin
        nxt_state = ST_HDR;
        ld_valid  = 1'b1;
        cnt_nxt   = '0;
      end else begin
        nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= cnt_nxt;
    end
  end

  typed_param_streamer_oreg #(.W(DATA_W + 1)) u_oreg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ld_valid),
    .in_data  ({ld_last, ld_data}),
    .out_valid(out_valid),
    .out_data ({out_last, out_data}),
    .out_ready(out_ready)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_typed_param_streamer.sv
// Self-checking bench: several typed_param_streamer configurations driven
// against a byte-stream reference model, with randomized backpressure.
module tb_typed_param_streamer;

`ifdef TYPED_PARAM_STREAMER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  localparam int N = 5;

  typedef logic [31:0] wq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st  [N];
  logic        rdy [N];
  logic        vld [N];
  logic        lst [N];
  logic        bsy [N];
  logic        dn  [N];
  logic [31:0] dat [N];

  logic [15:0] d0;
  logic [7:0]  d1;
  logic [31:0] d2;
  logic [23:0] d3;
  logic [15:0] d4;

  int    w_of  [N];
  int    iv_of [N];
  string s_of  [N];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign dat[0] = 32'(d0);
  assign dat[1] = 32'(d1);
  assign dat[2] = d2;
  assign dat[3] = 32'(d3);
  assign dat[4] = 32'(d4);

  typed_param_streamer #(.DATA_W(16), .INTEGER_PARAM(10), .STRING_PARAM("test"), .REPEAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
    .out_data(d0), .out_last(lst[0]), .busy(bsy[0]), .done(dn[0]));
  typed_param_streamer #(.DATA_W(8), .INTEGER_PARAM(10), .STRING_PARAM("abc"), .REPEAT(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
    .out_data(d1), .out_last(lst[1]), .busy(bsy[1]), .done(dn[1]));
  typed_param_streamer #(.DATA_W(32), .INTEGER_PARAM(300), .STRING_PARAM(""), .REPEAT(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
    .out_data(d2), .out_last(lst[2]), .busy(bsy[2]), .done(dn[2]));
  typed_param_streamer #(.DATA_W(24), .INTEGER_PARAM(4660), .STRING_PARAM("hello"), .REPEAT(1'b0)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .out_valid(vld[3]), .out_ready(rdy[3]),
    .out_data(d3), .out_last(lst[3]), .busy(bsy[3]), .done(dn[3]));
  typed_param_streamer #(.DATA_W(16), .INTEGER_PARAM(10), .STRING_PARAM("test"), .REPEAT(1'b1)) u4 (
    .clk(clk), .rst(rst), .start(st[4]), .out_valid(vld[4]), .out_ready(rdy[4]),
    .out_data(d4), .out_last(lst[4]), .busy(bsy[4]), .done(dn[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected transfer: header, then the string as a zero-padded byte stream
  // cut into words, then the XOR of the message words when enabled.
  function automatic wq_t model(input int i);
    wq_t         q;
    logic [7:0]  bytes [$];
    logic [31:0] w, x, mask;
    int          cpw;
    string       s;
    s    = s_of[i];
    cpw  = w_of[i] / 8;
    mask = (w_of[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w_of[i]) - 32'd1);
    q.push_back(32'(iv_of[i]) & mask);
    for (int c = 0; c < s.len(); c++) bytes.push_back(s[c]);
    while (bytes.size() % cpw != 0) bytes.push_back(8'h00);
    x = '0;
    while (bytes.size() > 0) begin
      w = '0;
      for (int b = 0; b < cpw; b++) w[8*b +: 8] = bytes.pop_front();
      q.push_back(w);
      x ^= w;
    end
    if (CHK_ON) q.push_back(x);
    return q;
  endfunction

  // mode 0: ready always high, 1: ready toggles, 2: random ready and random start while busy
  task automatic run_xfer(input int i, input int mode, input string tag);
    wq_t         exp;
    int          n_words, busy_cnt, budget;
    logic        held, held_l;
    logic [31:0] held_d, e;
    exp      = model(i);
    n_words  = exp.size();
    busy_cnt = 0;
    budget   = 0;
    held     = 1'b0;
    held_l   = 1'b0;
    held_d   = '0;
    @(negedge clk); st[i] = 1'b1;
    @(negedge clk); st[i] = 1'b0;
    check({tag, "_first_valid"}, 32'(vld[i]), 32'd1);
    while (exp.size() > 0 && budget < 400) begin
      if (bsy[i]) busy_cnt++;
      if (held) begin
        check({tag, "_hold_valid"}, 32'(vld[i]), 32'd1);
        check({tag, "_hold_data"}, dat[i], held_d);
        check({tag, "_hold_last"}, 32'(lst[i]), 32'(held_l));
      end
      case (mode)
        0:       rdy[i] = 1'b1;
        1:       rdy[i] = (budget % 2 == 0);
        default: rdy[i] = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) st[i] = 1'($urandom_range(0, 1));
      if (vld[i] && rdy[i]) begin
        e = exp.pop_front();
        check({tag, "_data"}, dat[i], e);
        check({tag, "_last"}, 32'(lst[i]), 32'(exp.size() == 0));
        held = 1'b0;
      end else begin
        held   = vld[i];
        held_d = dat[i];
        held_l = lst[i];
      end
      budget++;
      @(negedge clk);
    end
    st[i] = 1'b0;
    check({tag, "_drained"}, 32'(exp.size()), 32'd0);
    check({tag, "_done_pulse"}, 32'(dn[i]), 32'd1);
    check({tag, "_done_novalid"}, 32'(vld[i]), 32'd0);
    if (bsy[i]) busy_cnt++;
    if (mode == 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n_words + 1));
    rdy[i] = 1'b1;
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(dn[i]), 32'd0);
    check({tag, "_idle"}, 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t ref4;
    int  nw4, phase;

    w_of  = '{16, 8, 32, 24, 16};
    iv_of = '{10, 10, 300, 4660, 10};
    s_of  = '{"test", "abc", "", "hello", "test"};
    for (int i = 0; i < N; i++) begin
      st[i]  = 1'b0;
      rdy[i] = 1'b1;
    end

    #1;
    for (int i = 0; i < N; i++) begin
      check("reset_valid", 32'(vld[i]), 32'd0);
      check("reset_data", dat[i], 32'd0);
      check("reset_busy", 32'(bsy[i]), 32'd0);
      check("reset_done", 32'(dn[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_xfer(0, 0, "w16_test");
    run_xfer(1, 1, "w8_toggle");
    run_xfer(2, 0, "w32_empty");
    run_xfer(3, 0, "w24_pad");

    // Abort while the second message word is on the bus.
    rdy[0] = 1'b1;
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_word", dat[0], 32'h7473);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(vld[0]), 32'd0);
    check("abort_data", dat[0], 32'd0);
    check("abort_last", 32'(lst[0]), 32'd0);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_done", 32'(dn[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(dn[0]), 32'd0);
      check("abort_stay_idle", 32'(bsy[0]), 32'd0);
    end
    run_xfer(0, 0, "w16_restart");

    for (int r = 0; r < 8; r++) run_xfer(int'($urandom_range(0, 3)), 2, "rnd");

    // Free-running repeat: the stream loops with one done cycle between loops.
    ref4 = model(4);
    nw4  = ref4.size();
    rdy[4] = 1'b1;
    @(negedge clk); st[4] = 1'b1;
    @(negedge clk); st[4] = 1'b0;
    for (int c = 0; c < 3 * (nw4 + 1); c++) begin
      phase = c % (nw4 + 1);
      if (phase < nw4) begin
        check("rep_valid", 32'(vld[4]), 32'd1);
        check("rep_data", dat[4], ref4[phase]);
        check("rep_last", 32'(lst[4]), 32'(phase == nw4 - 1));
        check("rep_no_done", 32'(dn[4]), 32'd0);
      end else begin
        check("rep_done", 32'(dn[4]), 32'd1);
        check("rep_done_novalid", 32'(vld[4]), 32'd0);
      end
      check("rep_busy", 32'(bsy[4]), 32'd1);
      st[4] = (c == 5);
      @(negedge clk);
    end
    st[4] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
